// File: rtl/adder4_pkg.sv
// Shared defaults and FSM state type for the round-robin shared-adder scheduler.
package adder4_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/adder4.sv
// Combinational W-bit unsigned adder with a W+1-bit sum, so no carry is lost.
module adder4
  import adder4_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum_c
);

  assign sum_c = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder4_rr_scheduler.sv
// Round-robin scheduler sharing one adder among NREQ requesters; the result is
// registered with the winner's id and offered on a valid/ready response port.
module adder4_rr_scheduler
  import adder4_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  parameter  int unsigned W    = W_DEF,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [W:0]        sum_q, sum_d;
  logic              valid_q, valid_d;

  logic [W-1:0]      a_arr [NREQ];
  logic [W-1:0]      b_arr [NREQ];
  logic [W-1:0]      a_sel_c, b_sel_c;
  logic [W:0]        add_sum_c;
  logic [IDW-1:0]    win_c;
  logic              any_req_c;
  logic              can_accept_c;
  logic              accept_c;
  logic [NREQ-1:0]   gnt_c;
  int unsigned       idx_c;

  // Unpack the flat operand buses into per-requester lanes.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      a_arr[i] = a_flat[i*W +: W];
      b_arr[i] = b_flat[i*W +: W];
    end
  end

  // Round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win_c     = '0;
    any_req_c = 1'b0;
    idx_c     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = 32'(ptr_q) + k;
      if (idx_c >= NREQ) begin
        idx_c = idx_c - NREQ;
      end
      if (!any_req_c && req[IDW'(idx_c)]) begin
        any_req_c = 1'b1;
        win_c     = IDW'(idx_c);
      end
    end
  end

  assign a_sel_c = a_arr[win_c];
  assign b_sel_c = b_arr[win_c];

  adder4 #(
    .W (W)
  ) u_adder4 (
    .a     (a_sel_c),
    .b     (b_sel_c),
    .sum_c (add_sum_c)
  );

  // Next-state and grant logic; a new accept may overlap a response being consumed.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    sum_d        = sum_q;
    gnt_c        = '0;
    can_accept_c = (state_q == IDLE) || rsp_ready;
    accept_c     = can_accept_c && any_req_c && !rst;

    if (accept_c) begin
      gnt_c[win_c] = 1'b1;
      ptr_d        = (win_c == IDW'(NREQ - 1)) ? '0 : win_c + IDW'(1);
      id_d         = win_c;
      sum_d        = add_sum_c;
      state_d      = RESP;
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end

    valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign gnt       = gnt_c;
  assign rsp_valid = valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;

endmodule
